regf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order writeback stage (WB) and the

---
 rtl/regf_pkg.sv | 23 ++
 rtl/regf_wb_arbiter_if.sv | 36 +++
 rtl/regf_scoreboard.sv | 41 ++++
 rtl/regf_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regf_wb_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/regf_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
package regf_pkg;

  localparam int IS_DEPTH       = 5;
  localparam int REGF_DEPTH     = 32;
  localparam int REGF_WIDTH     = 32;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [IS_DEPTH-1:0] REG_X0 = '0;

  typedef enum logic {
    PRI_WB = 1'b0,
    PRI_LU = 1'b1
  } arb_state_t;

  // One-hot mask selecting a single scoreboard entry.
  function automatic logic [REGF_DEPTH-1:0] reg_onehot(input logic [IS_DEPTH-1:0] idx);
    logic [REGF_DEPTH-1:0] one;
    one = {{(REGF_DEPTH-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/regf_wb_arbiter_if.sv
// Bundle of WB/LU/issue handshakes, decode lookups and register-file write signals.
interface regf_wb_arbiter_if;
  import regf_pkg::*;

  logic                  wb_valid;
  logic [IS_DEPTH-1:0]   wb_rd;
  logic [REGF_WIDTH-1:0] wb_data;
  logic                  wb_ready;
  logic                  lu_valid;
  logic [IS_DEPTH-1:0]   lu_rd;
  logic [REGF_WIDTH-1:0] lu_data;
  logic                  lu_ready;
  logic                  iss_valid;
  logic [IS_DEPTH-1:0]   iss_rd;
  logic                  iss_ready;
  logic [IS_DEPTH-1:0]   rs1;
  logic [IS_DEPTH-1:0]   rs2;
  logic                  hazard;
  logic                  regWrite;
  logic [IS_DEPTH-1:0]   rd;
  logic [REGF_WIDTH-1:0] data_wr;
  logic                  waw_err;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs1, rs2,
    input  wb_ready, lu_ready, iss_ready, hazard, regWrite, rd, data_wr, waw_err
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs1, rs2,
    output wb_ready, lu_ready, iss_ready, hazard, regWrite, rd, data_wr, waw_err
  );

endinterface

// File: rtl/regf_scoreboard.sv
// Pending-destination scoreboard for long-latency ops; x0 is never marked.
module regf_scoreboard
  import regf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [IS_DEPTH-1:0]   set_idx,
  input  logic                  clr_en,
  input  logic [IS_DEPTH-1:0]   clr_idx,
  input  logic [IS_DEPTH-1:0]   lkp_a_idx,
  input  logic [IS_DEPTH-1:0]   lkp_b_idx,
  output logic                  lkp_a_hit,
  output logic                  lkp_b_hit,
  output logic [REGF_DEPTH-1:0] pending_o
);

  logic [REGF_DEPTH-1:0] pending_d, pending_q;
  logic [REGF_DEPTH-1:0] set_mask_s, clr_mask_s;

  // Next pending vector: a set of one register and a clear of another both land.
  always_comb begin
    clr_mask_s = clr_en ? reg_onehot(clr_idx) : {REGF_DEPTH{1'b0}};
    set_mask_s = (set_en && (set_idx != REG_X0)) ? reg_onehot(set_idx) : {REGF_DEPTH{1'b0}};
    pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= {REGF_DEPTH{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign lkp_a_hit = (lkp_a_idx != REG_X0) && pending_q[lkp_a_idx];
  assign lkp_b_hit = (lkp_b_idx != REG_X0) && pending_q[lkp_b_idx];
  assign pending_o = pending_q;

endmodule

// File: rtl/regf_wb_arbiter.sv
// Arbitrates the single register-file write port between WB and the long-latency unit,
// with an anti-starvation priority flip and a one-cycle registered write stage.
module regf_wb_arbiter
  import regf_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  regf_wb_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STARVE_MAX - 1);

  arb_state_t            state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  regwrite_d, regwrite_q;
  logic [IS_DEPTH-1:0]   rd_d, rd_q;
  logic [REGF_WIDTH-1:0] data_d, data_q;
  logic                  waw_d, waw_q;

  logic                  wb_hs_s, lu_hs_s, iss_hs_s, wr_en_s;
  logic [IS_DEPTH-1:0]   grant_rd_s;
  logic [REGF_WIDTH-1:0] grant_data_s;
  logic [REGF_DEPTH-1:0] pending_s;
  logic                  hit1_s, hit2_s;

  regf_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_hs_s),
    .set_idx   (bus.iss_rd),
    .clr_en    (lu_hs_s),
    .clr_idx   (bus.lu_rd),
    .lkp_a_idx (bus.rs1),
    .lkp_b_idx (bus.rs2),
    .lkp_a_hit (hit1_s),
    .lkp_b_hit (hit2_s),
    .pending_o (pending_s)
  );

  // Grant, starvation counter and priority next-state.
  always_comb begin
    lu_hs_s = bus.lu_valid && (!bus.wb_valid || (state_q == PRI_LU));
    wb_hs_s = bus.wb_valid && !lu_hs_s;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (lu_hs_s || !bus.lu_valid) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      PRI_WB: begin
        if (bus.lu_valid && !lu_hs_s && (cnt_q == CNT_TOP)) begin
          state_d = PRI_LU;
        end else begin
          state_d = PRI_WB;
        end
      end
      PRI_LU: begin
        if (lu_hs_s) begin
          state_d = PRI_WB;
        end else begin
          state_d = PRI_LU;
        end
      end
      default: state_d = PRI_WB;
    endcase
  end

  // Write-stage next values; x0 handshakes complete but never write.
  always_comb begin
    grant_rd_s   = lu_hs_s ? bus.lu_rd   : bus.wb_rd;
    grant_data_s = lu_hs_s ? bus.lu_data : bus.wb_data;
    wr_en_s      = (wb_hs_s || lu_hs_s) && (grant_rd_s != REG_X0);
    regwrite_d   = wr_en_s;
    rd_d         = wr_en_s ? grant_rd_s   : rd_q;
    data_d       = wr_en_s ? grant_data_s : data_q;
    waw_d        = waw_q || (wb_hs_s && (bus.wb_rd != REG_X0) && pending_s[bus.wb_rd]);
  end

  // State and write-stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PRI_WB;
      cnt_q      <= {CNT_W{1'b0}};
      regwrite_q <= 1'b0;
      rd_q       <= {IS_DEPTH{1'b0}};
      data_q     <= {REGF_WIDTH{1'b0}};
      waw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      waw_q      <= waw_d;
    end
  end

  assign iss_hs_s      = bus.iss_valid && bus.iss_ready;
  assign bus.iss_ready = !pending_s[bus.iss_rd];
  assign bus.wb_ready  = wb_hs_s;
  assign bus.lu_ready  = lu_hs_s;
  assign bus.hazard    = hit1_s || hit2_s;
  assign bus.regWrite  = regwrite_q;
  assign bus.rd        = rd_q;
  assign bus.data_wr   = data_q;
  assign bus.waw_err   = waw_q;

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed bench for regf_wb_arbiter with an expected-write queue checked against the write stage.
module tb_regf_wb_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [36:0] exp_q[$];
  logic        exp_wr;

  regf_wb_arbiter_if bus ();

  regf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1 with inputs driven; checks grants, crosses one edge, checks write stage.
  task automatic step(input string tag, input logic exp_wb, input logic exp_lu);
    logic [36:0] e;
    #1;
    chk({tag, ".wb_ready"}, {31'd0, bus.wb_ready}, {31'd0, exp_wb});
    chk({tag, ".lu_ready"}, {31'd0, bus.lu_ready}, {31'd0, exp_lu});
    exp_wr = 1'b0;
    if (exp_wb && bus.wb_rd != 5'd0) begin
      exp_q.push_back({bus.wb_rd, bus.wb_data});
      exp_wr = 1'b1;
    end
    if (exp_lu && bus.lu_rd != 5'd0) begin
      exp_q.push_back({bus.lu_rd, bus.lu_data});
      exp_wr = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".regWrite"}, {31'd0, bus.regWrite}, {31'd0, exp_wr});
    if (exp_wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".rd"}, {27'd0, bus.rd}, {27'd0, e[36:32]});
      chk({tag, ".data_wr"}, bus.data_wr, e[31:0]);
    end
  endtask

  task automatic idle();
    bus.wb_valid  = 1'b0;
    bus.lu_valid  = 1'b0;
    bus.iss_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.lu_valid = 1'b0; bus.lu_rd = 5'd0; bus.lu_data = 32'd0;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    bus.rs1 = 5'd7; bus.rs2 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("rst.rd", {27'd0, bus.rd}, 32'd0);
    chk("rst.data_wr", bus.data_wr, 32'd0);
    chk("rst.waw_err", {31'd0, bus.waw_err}, 32'd0);
    chk("rst.hazard", {31'd0, bus.hazard}, 32'd0);
    rst = 1'b1;

    // WB alone
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    step("wb_only", 1'b1, 1'b0);
    idle();
    step("wb_idle", 1'b0, 1'b0);

    // Starvation: WB wins four cycles, LU the fifth, then WB again
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd2; bus.lu_data = 32'h0000_1234;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1;
    for (int i = 0; i < 4; i++) begin
      bus.wb_data = 32'hA000_0000 + 32'(i);
      step($sformatf("starve%0d", i), 1'b1, 1'b0);
    end
    bus.wb_data = 32'hA000_0004;
    step("starve_lu", 1'b0, 1'b1);
    bus.lu_rd = 5'd4; bus.lu_data = 32'h0000_5678;
    step("starve_back", 1'b1, 1'b0);
    idle();
    step("starve_idle", 1'b0, 1'b0);

    // Scoreboard reservation of x7
    bus.rs1 = 5'd7; bus.rs2 = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    chk("sb.iss_ready0", {31'd0, bus.iss_ready}, 32'd1);
    chk("sb.hazard_pre", {31'd0, bus.hazard}, 32'd0);
    step("sb_issue", 1'b0, 1'b0);
    chk("sb.hazard_set", {31'd0, bus.hazard}, 32'd1);
    chk("sb.iss_block", {31'd0, bus.iss_ready}, 32'd0);
    step("sb_reissue", 1'b0, 1'b0);
    bus.iss_valid = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h7777_0007;
    #1;
    chk("sb.hazard_hs", {31'd0, bus.hazard}, 32'd1);
    step("sb_lu_wr", 1'b0, 1'b1);
    idle();
    #1;
    chk("sb.hazard_clr", {31'd0, bus.hazard}, 32'd0);
    chk("sb.iss_free", {31'd0, bus.iss_ready}, 32'd1);

    // Same-cycle set of x9 and clear of x8
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd8;
    step("sb_iss8", 1'b0, 1'b0);
    bus.iss_rd = 5'd9;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd8; bus.lu_data = 32'h8888_0008;
    step("sb_set_clr", 1'b0, 1'b1);
    idle();
    bus.rs1 = 5'd8; bus.rs2 = 5'd9;
    #1;
    chk("sb.x8_clear", {31'd0, bus.hazard}, 32'd1);
    bus.rs2 = 5'd0;
    #1;
    chk("sb.x8_only", {31'd0, bus.hazard}, 32'd0);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h9999_0009;
    step("sb_clr9", 1'b0, 1'b1);
    idle();

    // x0 handling
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h0BAD_0BAD;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1;
    chk("x0.iss_ready", {31'd0, bus.iss_ready}, 32'd1);
    step("x0_wb", 1'b1, 1'b0);
    idle();
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    #1;
    chk("x0.hazard", {31'd0, bus.hazard}, 32'd0);
    chk("x0.iss_again", {31'd0, bus.iss_ready}, 32'd1);

    // WAW: reserve x3 then WB writes it
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    step("waw_iss", 1'b0, 1'b0);
    idle();
    chk("waw.before", {31'd0, bus.waw_err}, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h3333_0003;
    step("waw_wb", 1'b1, 1'b0);
    idle();
    chk("waw.set", {31'd0, bus.waw_err}, 32'd1);
    step("waw_idle", 1'b0, 1'b0);
    chk("waw.sticky", {31'd0, bus.waw_err}, 32'd1);

    // Reset mid-traffic after driving the arbiter into LU priority
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd6; bus.lu_data = 32'h6666_0006;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      bus.wb_data = 32'hB000_0000 + 32'(i);
      step($sformatf("pre_rst%0d", i), 1'b1, 1'b0);
    end
    bus.rs1 = 5'd3;
    bus.iss_rd = 5'd3;
    rst = 1'b0;
    #1;
    chk("mid_rst.regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("mid_rst.rd", {27'd0, bus.rd}, 32'd0);
    chk("mid_rst.data_wr", bus.data_wr, 32'd0);
    chk("mid_rst.waw_err", {31'd0, bus.waw_err}, 32'd0);
    chk("mid_rst.hazard", {31'd0, bus.hazard}, 32'd0);
    chk("mid_rst.iss_ready", {31'd0, bus.iss_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.wb_data = 32'hC000_0001;
    step("post_rst", 1'b1, 1'b0);
    idle();
    step("post_idle", 1'b0, 1'b0);
    chk("post_rst.waw", {31'd0, bus.waw_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
